// File: rtl/coderom_bus_ctl.sv
// coderom_bus_ctl: 68000-side bus controller for the 4x(8Kx16) program ROM bank.
// It decodes CPU accesses to the ROM region and latches the word address. It drives the bank's
// active-low chip enables and 13-bit address. It waits out the bank's one-clock registered read
// latency, then captures the read word and returns DTACK after WAIT_STATES extra clocks.
// Optional build macro: CODEROM_WRITE_TRAP_EN
//   undefined : writes to the ROM region are acknowledged as silent no-ops; cpu_berr_n tied high.
//   defined   : writes to the ROM region raise BERR two clocks after the hit instead of DTACK.
module coderom_bus_ctl #(
  parameter int unsigned WAIT_STATES = 1,      // 0..7 extra clocks between capture and DTACK
  parameter logic [7:0]  ROM_BASE    = 8'h00   // cpu_a[23:16] value of the 64 KB ROM window
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:1] cpu_a,
  input  logic        cpu_as_n,
  input  logic        cpu_rw,
  input  logic        cpu_uds_n,
  input  logic        cpu_lds_n,
  output logic [15:0] cpu_d_out,
  output logic        cpu_dtack_n,
  output logic        cpu_berr_n,
  output logic [12:0] rom_a,
  output logic [3:0]  rom_ce_n,
  input  logic [15:0] rom_q,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_WAIT = 3'd3,
    ST_ACK  = 3'd4,
    ST_BERR = 3'd5
  } state_t;

`ifdef CODEROM_WRITE_TRAP_EN
  localparam bit WRITE_TRAP = 1'b1;
`else
  localparam bit WRITE_TRAP = 1'b0;
`endif

  state_t      state_reg, state_next;
  logic        is_read_reg, is_read_next;
  logic [2:0]  wait_cnt_reg, wait_cnt_next;
  logic [3:0]  ce_n_reg, ce_n_next;
  logic [12:0] rom_a_reg, rom_a_next;
  logic [15:0] d_out_reg, d_out_next;
  logic        dtack_n_reg, dtack_n_next;
  logic        hit;

  // A ROM-region access with at least one byte strobe active; byte strobes never gate the read.
  assign hit = ~cpu_as_n & (cpu_a[23:16] == ROM_BASE) & (~cpu_uds_n | ~cpu_lds_n);

  // State register; async reset returns the controller to IDLE from anywhere.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; AS# going high before DTACK aborts the cycle without acknowledging it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (hit) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        state_next = cpu_as_n ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (cpu_as_n)                      state_next = ST_IDLE;
        else if (WRITE_TRAP && !is_read_reg) state_next = ST_BERR;
        else if (WAIT_STATES == 0)         state_next = ST_ACK;
        else                               state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (cpu_as_n)                  state_next = ST_IDLE;
        else if (wait_cnt_reg == 3'd1) state_next = ST_ACK;
        else                           state_next = ST_WAIT;
      end
      ST_ACK: begin
        if (cpu_as_n) state_next = ST_IDLE;
      end
      ST_BERR: begin
        if (cpu_as_n) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output/datapath next values; every CPU- and ROM-facing output is a register loaded from here.
  always_comb begin
    is_read_next  = is_read_reg;
    wait_cnt_next = wait_cnt_reg;
    ce_n_next     = ce_n_reg;
    rom_a_next    = rom_a_reg;
    d_out_next    = d_out_reg;
    dtack_n_next  = (state_next != ST_ACK);

    if (state_reg == ST_IDLE) begin
      // Latch direction and, for reads only, the word address and chip select at the hit edge.
      if (hit) begin
        is_read_next = cpu_rw;
        if (cpu_rw) begin
          rom_a_next             = cpu_a[13:1];
          ce_n_next              = 4'hF;
          ce_n_next[cpu_a[15:14]] = 1'b0;
        end
      end
    end else if (state_next == ST_IDLE) begin
      // Leaving an access (completion or abort) always deselects the whole bank.
      ce_n_next = 4'hF;
    end

    // The bank registered its data one clock after the address; take it unless aborted.
    if (state_reg == ST_DATA && !cpu_as_n) begin
      wait_cnt_next = 3'(WAIT_STATES);
      if (is_read_reg) d_out_next = rom_q;
    end

    if (state_reg == ST_WAIT && !cpu_as_n) begin
      wait_cnt_next = wait_cnt_reg - 3'd1;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_read_reg  <= 1'b0;
      wait_cnt_reg <= 3'd0;
      ce_n_reg     <= 4'hF;
      rom_a_reg    <= 13'd0;
      d_out_reg    <= 16'd0;
      dtack_n_reg  <= 1'b1;
    end else begin
      is_read_reg  <= is_read_next;
      wait_cnt_reg <= wait_cnt_next;
      ce_n_reg     <= ce_n_next;
      rom_a_reg    <= rom_a_next;
      d_out_reg    <= d_out_next;
      dtack_n_reg  <= dtack_n_next;
    end
  end

`ifdef CODEROM_WRITE_TRAP_EN
  logic berr_n_reg;

  // Bus error is asserted for the whole time the FSM sits in the trap state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      berr_n_reg <= 1'b1;
    end else begin
      berr_n_reg <= (state_next != ST_BERR);
    end
  end

  assign cpu_berr_n = berr_n_reg;
`else
  assign cpu_berr_n = 1'b1;
`endif

  assign cpu_d_out   = d_out_reg;
  assign cpu_dtack_n = dtack_n_reg;
  assign rom_a       = rom_a_reg;
  assign rom_ce_n    = ce_n_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule
